// File: rtl/riscv_pcctrl_if.sv
// Fetch-stage next-PC bundle: core-side request/target inputs and PC-control outputs.
// master = pipeline side driving requests, slave = riscv_pcctrl.
interface riscv_pcctrl_if;
   logic [63:0] i_riscv_pcctrl_pc;
   logic        i_riscv_pcctrl_cinst;
   logic        i_riscv_pcctrl_fstall;
   logic        i_riscv_pcctrl_br_vld;
   logic [63:0] i_riscv_pcctrl_br_tgt;
   logic        i_riscv_pcctrl_trap_vld;
   logic [63:0] i_riscv_pcctrl_trap_tgt;
   logic        i_riscv_pcctrl_mret_vld;
   logic [63:0] i_riscv_pcctrl_mret_tgt;
   logic [63:0] o_riscv_pcctrl_nextpc;
   logic        o_riscv_pcctrl_stallpc;
   logic        o_riscv_pcctrl_flush_fd;
   logic        o_riscv_pcctrl_flush_de;
   logic        o_riscv_pcctrl_pend;
   logic [31:0] o_riscv_pcctrl_redir_cnt;

   modport master (
      output i_riscv_pcctrl_pc, i_riscv_pcctrl_cinst, i_riscv_pcctrl_fstall,
             i_riscv_pcctrl_br_vld, i_riscv_pcctrl_br_tgt,
             i_riscv_pcctrl_trap_vld, i_riscv_pcctrl_trap_tgt,
             i_riscv_pcctrl_mret_vld, i_riscv_pcctrl_mret_tgt,
      input  o_riscv_pcctrl_nextpc, o_riscv_pcctrl_stallpc, o_riscv_pcctrl_flush_fd,
             o_riscv_pcctrl_flush_de, o_riscv_pcctrl_pend, o_riscv_pcctrl_redir_cnt
   );

   modport slave (
      input  i_riscv_pcctrl_pc, i_riscv_pcctrl_cinst, i_riscv_pcctrl_fstall,
             i_riscv_pcctrl_br_vld, i_riscv_pcctrl_br_tgt,
             i_riscv_pcctrl_trap_vld, i_riscv_pcctrl_trap_tgt,
             i_riscv_pcctrl_mret_vld, i_riscv_pcctrl_mret_tgt,
      output o_riscv_pcctrl_nextpc, o_riscv_pcctrl_stallpc, o_riscv_pcctrl_flush_fd,
             o_riscv_pcctrl_flush_de, o_riscv_pcctrl_pend, o_riscv_pcctrl_redir_cnt
   );
endinterface

// File: rtl/riscv_pcctrl.sv
// Next-PC controller for the fetch stage: sequential/branch/trap/mret selection, stall and
// flush generation, a one-entry pending redirect buffer and a redirect event counter.
module riscv_pcctrl #(
   parameter logic [63:0] RESET_PC = 64'h101AE
) (
   input  logic          i_riscv_pcctrl_clk,
   input  logic          i_riscv_pcctrl_rst_n,
   riscv_pcctrl_if.slave pc_bus
);

   typedef enum logic [0:0] {StRun, StPend} state_e;

   // Source codes are ordered so that a numeric compare gives redirect priority.
   localparam logic [1:0] SrcNone = 2'd0;
   localparam logic [1:0] SrcBr   = 2'd1;
   localparam logic [1:0] SrcMret = 2'd2;
   localparam logic [1:0] SrcTrap = 2'd3;

   localparam logic [63:0] AlignMask = ~64'h1;

   state_e      state_q;
   logic [1:0]  pend_src_q;
   logic [63:0] pend_tgt_q;
   logic [31:0] redir_cnt_q;
   logic        rst_exit_q;

   logic        trap_req;
   logic        mret_req;
   logic        br_req;
   logic [1:0]  win_src;
   logic [63:0] win_tgt;
   logic        win_vld;
   logic [1:0]  ctl_src;
   logic [63:0] ctl_tgt;
   logic        ctl_take;
   logic [63:0] seq_pc;

   // Requests are masked off while leaving reset.
   assign trap_req = pc_bus.i_riscv_pcctrl_trap_vld & ~rst_exit_q;
   assign mret_req = pc_bus.i_riscv_pcctrl_mret_vld & ~rst_exit_q;
   assign br_req   = pc_bus.i_riscv_pcctrl_br_vld & ~rst_exit_q;

   assign seq_pc = pc_bus.i_riscv_pcctrl_pc + (pc_bus.i_riscv_pcctrl_cinst ? 64'd2 : 64'd4);

   always_comb begin
      win_src = SrcNone;
      win_tgt = '0;
      if (trap_req) begin
         win_src = SrcTrap;
         win_tgt = pc_bus.i_riscv_pcctrl_trap_tgt & AlignMask;
      end else if (mret_req) begin
         win_src = SrcMret;
         win_tgt = pc_bus.i_riscv_pcctrl_mret_tgt & AlignMask;
      end else if (br_req) begin
         win_src = SrcBr;
         win_tgt = pc_bus.i_riscv_pcctrl_br_tgt & AlignMask;
      end
   end

   assign win_vld = (win_src != SrcNone);

   // While pending only trap/mret may take over (branches come from the wrong path); a
   // lower-priority one than the latched entry is dropped.
   always_comb begin
      ctl_src = SrcNone;
      ctl_tgt = '0;
      if (trap_req) begin
         ctl_src = SrcTrap;
         ctl_tgt = pc_bus.i_riscv_pcctrl_trap_tgt & AlignMask;
      end else if (mret_req) begin
         ctl_src = SrcMret;
         ctl_tgt = pc_bus.i_riscv_pcctrl_mret_tgt & AlignMask;
      end
   end

   assign ctl_take = (ctl_src != SrcNone) && (ctl_src >= pend_src_q);

   // Flushes depend only on requests and state, never on fstall.
   always_comb begin
      pc_bus.o_riscv_pcctrl_nextpc   = seq_pc;
      pc_bus.o_riscv_pcctrl_stallpc  = pc_bus.i_riscv_pcctrl_fstall;
      pc_bus.o_riscv_pcctrl_flush_fd = 1'b0;
      pc_bus.o_riscv_pcctrl_flush_de = 1'b0;
      if (rst_exit_q) begin
         pc_bus.o_riscv_pcctrl_nextpc  = RESET_PC;
         pc_bus.o_riscv_pcctrl_stallpc = 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (win_vld) begin
                  pc_bus.o_riscv_pcctrl_nextpc   = win_tgt;
                  pc_bus.o_riscv_pcctrl_flush_fd = 1'b1;
                  pc_bus.o_riscv_pcctrl_flush_de = 1'b1;
               end
            end
            StPend: begin
               pc_bus.o_riscv_pcctrl_nextpc   = ctl_take ? ctl_tgt : pend_tgt_q;
               pc_bus.o_riscv_pcctrl_flush_fd = ctl_take;
               pc_bus.o_riscv_pcctrl_flush_de = ctl_take;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_riscv_pcctrl_clk or negedge i_riscv_pcctrl_rst_n) begin
      if (!i_riscv_pcctrl_rst_n) begin
         state_q     <= StRun;
         pend_src_q  <= SrcNone;
         pend_tgt_q  <= '0;
         redir_cnt_q <= '0;
         rst_exit_q  <= 1'b1;
      end else if (rst_exit_q) begin
         rst_exit_q <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (win_vld) begin
                  if (pc_bus.i_riscv_pcctrl_fstall) begin
                     state_q    <= StPend;
                     pend_src_q <= win_src;
                     pend_tgt_q <= win_tgt;
                  end else begin
                     redir_cnt_q <= redir_cnt_q + 32'd1;
                  end
               end
            end
            StPend: begin
               if (pc_bus.i_riscv_pcctrl_fstall) begin
                  if (ctl_take) begin
                     pend_src_q <= ctl_src;
                     pend_tgt_q <= ctl_tgt;
                  end
               end else begin
                  state_q     <= StRun;
                  pend_src_q  <= SrcNone;
                  redir_cnt_q <= redir_cnt_q + 32'd1;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   assign pc_bus.o_riscv_pcctrl_pend      = (state_q == StPend);
   assign pc_bus.o_riscv_pcctrl_redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_riscv_pcctrl.sv
// Scoreboard bench for riscv_pcctrl: directed vectors push expected outputs, a negedge
// monitor pops and compares them.
module tb_riscv_pcctrl;

   typedef struct {
      string       name;
      logic [5:0]  mask;
      logic [63:0] nextpc;
      logic        stall;
      logic        ffd;
      logic        fde;
      logic        pend;
      logic [31:0] cnt;
   } exp_t;

   localparam logic [5:0] MAll  = 6'h3F;
   localparam logic [5:0] MNoPc = 6'h3E;

   logic clk;
   logic rst_n;
   exp_t sb_q[$];
   int   n_assert;
   int   n_fail;

   riscv_pcctrl_if bus();

   riscv_pcctrl #(.RESET_PC(64'h101AE)) dut (
      .i_riscv_pcctrl_clk   (clk),
      .i_riscv_pcctrl_rst_n (rst_n),
      .pc_bus               (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         if (e.mask[0]) chk({e.name, ".nextpc"}, bus.o_riscv_pcctrl_nextpc, e.nextpc);
         if (e.mask[1]) chk({e.name, ".stallpc"}, 64'(bus.o_riscv_pcctrl_stallpc), 64'(e.stall));
         if (e.mask[2]) chk({e.name, ".flush_fd"}, 64'(bus.o_riscv_pcctrl_flush_fd), 64'(e.ffd));
         if (e.mask[3]) chk({e.name, ".flush_de"}, 64'(bus.o_riscv_pcctrl_flush_de), 64'(e.fde));
         if (e.mask[4]) chk({e.name, ".pend"}, 64'(bus.o_riscv_pcctrl_pend), 64'(e.pend));
         if (e.mask[5]) chk({e.name, ".redir_cnt"}, 64'(bus.o_riscv_pcctrl_redir_cnt), 64'(e.cnt));
      end
   end

   task automatic drv(input logic [63:0] pc, input logic c, input logic fs,
                      input logic bv, input logic [63:0] bt,
                      input logic tv, input logic [63:0] tt,
                      input logic mv, input logic [63:0] mt);
      @(posedge clk);
      #1;
      bus.i_riscv_pcctrl_pc       = pc;
      bus.i_riscv_pcctrl_cinst    = c;
      bus.i_riscv_pcctrl_fstall   = fs;
      bus.i_riscv_pcctrl_br_vld   = bv;
      bus.i_riscv_pcctrl_br_tgt   = bt;
      bus.i_riscv_pcctrl_trap_vld = tv;
      bus.i_riscv_pcctrl_trap_tgt = tt;
      bus.i_riscv_pcctrl_mret_vld = mv;
      bus.i_riscv_pcctrl_mret_tgt = mt;
   endtask

   task automatic expect_out(input string nm, input logic [5:0] m, input logic [63:0] npc,
                             input logic st, input logic ffd, input logic fde,
                             input logic pend, input logic [31:0] cnt);
      exp_t e;
      e.name = nm; e.mask = m; e.nextpc = npc; e.stall = st;
      e.ffd = ffd; e.fde = fde; e.pend = pend; e.cnt = cnt;
      sb_q.push_back(e);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.i_riscv_pcctrl_pc       = '0;
      bus.i_riscv_pcctrl_cinst    = 1'b0;
      bus.i_riscv_pcctrl_fstall   = 1'b0;
      bus.i_riscv_pcctrl_br_vld   = 1'b0;
      bus.i_riscv_pcctrl_br_tgt   = '0;
      bus.i_riscv_pcctrl_trap_vld = 1'b0;
      bus.i_riscv_pcctrl_trap_tgt = '0;
      bus.i_riscv_pcctrl_mret_vld = 1'b0;
      bus.i_riscv_pcctrl_mret_tgt = '0;

      // Reset: redirect/stall inputs must be ignored
      drv(64'h0, 0, 1, 0, 0, 1, 64'h900, 0, 0);
      expect_out("rst_hold", MAll, 64'h101AE, 0, 0, 0, 0, 0);
      drv(64'h0, 0, 0, 1, 64'h3000, 0, 0, 0, 0);
      rst_n = 1'b1;
      expect_out("rst_exit", MAll, 64'h101AE, 0, 0, 0, 0, 0);
      drv(64'h101AE, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("first_seq", MAll, 64'h101B0, 0, 0, 0, 0, 0);

      // Sequential
      drv(64'h2000, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("seq4", MAll, 64'h2004, 0, 0, 0, 0, 0);
      drv(64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("seq_wrap", MAll, 64'h0, 0, 0, 0, 0, 0);
      drv(64'h1000, 0, 1, 0, 0, 0, 0, 0, 0);
      expect_out("seq_stall", MAll, 64'h1004, 1, 0, 0, 0, 0);

      // Simultaneous redirects, then mret alone
      drv(64'h1000, 0, 0, 1, 64'h3000, 1, 64'h8000_0000, 1, 64'h4001);
      expect_out("prio_trap", MAll, 64'h8000_0000, 0, 1, 1, 0, 0);
      drv(64'h8000_0000, 0, 0, 0, 0, 0, 0, 1, 64'h4001);
      expect_out("mret_only", MAll, 64'h4000, 0, 1, 1, 0, 1);
      drv(64'h4000, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("post_mret", MAll, 64'h4004, 0, 0, 0, 0, 2);

      // Branch while stalled
      drv(64'h4004, 0, 1, 1, 64'h5000, 0, 0, 0, 0);
      expect_out("br_stall", MNoPc, 64'h0, 1, 1, 1, 0, 2);
      for (int i = 0; i < 3; i++) begin
         drv(64'h4004, 0, 1, 0, 0, 0, 0, 0, 0);
         expect_out("pend_hold", MNoPc, 64'h0, 1, 0, 0, 1, 2);
      end
      drv(64'h4004, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("pend_release", MAll, 64'h5000, 0, 0, 0, 1, 2);
      drv(64'h5000, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_out("after_release", MAll, 64'h5002, 0, 0, 0, 0, 3);

      // Replacement by trap, later branch ignored
      drv(64'h5002, 0, 1, 1, 64'h5000, 0, 0, 0, 0);
      expect_out("repl_br", MNoPc, 64'h0, 1, 1, 1, 0, 3);
      drv(64'h5002, 0, 1, 0, 0, 1, 64'h101, 0, 0);
      expect_out("repl_trap", MNoPc, 64'h0, 1, 1, 1, 1, 3);
      drv(64'h5002, 0, 1, 1, 64'h6000, 0, 0, 0, 0);
      expect_out("pend_br_ign", MNoPc, 64'h0, 1, 0, 0, 1, 3);
      drv(64'h5002, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("repl_release", MAll, 64'h100, 0, 0, 0, 1, 3);
      drv(64'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("after_repl", MAll, 64'h104, 0, 0, 0, 0, 4);

      // Trap latched: mret is lower priority; trap at release wins over latched entry
      drv(64'h104, 0, 1, 0, 0, 1, 64'h200, 0, 0);
      expect_out("trap_stall", MNoPc, 64'h0, 1, 1, 1, 0, 4);
      drv(64'h104, 0, 1, 0, 0, 0, 0, 1, 64'h300);
      expect_out("mret_low", MNoPc, 64'h0, 1, 0, 0, 1, 4);
      drv(64'h104, 0, 0, 0, 0, 1, 64'h400, 0, 0);
      expect_out("trap_at_rel", MAll, 64'h400, 0, 1, 1, 1, 4);
      drv(64'h400, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("after_trap", MAll, 64'h404, 0, 0, 0, 0, 5);

      // Counter wrap
      drv(64'h404, 0, 0, 1, 64'h7000, 0, 0, 0, 0);
      force dut.redir_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.redir_cnt_q;
      expect_out("cnt_max", MAll, 64'h7000, 0, 1, 1, 0, 32'hFFFF_FFFF);
      drv(64'h7000, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("cnt_wrap", MAll, 64'h7004, 0, 0, 0, 0, 0);

      // Reset while pending
      drv(64'h7004, 0, 1, 1, 64'h8000, 0, 0, 0, 0);
      expect_out("pre_rst_br", MNoPc, 64'h0, 1, 1, 1, 0, 0);
      drv(64'h7004, 0, 1, 0, 0, 0, 0, 0, 0);
      expect_out("pre_rst_pend", MNoPc, 64'h0, 1, 0, 0, 1, 0);
      drv(64'h7004, 0, 1, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      expect_out("rst_mid_pend", MAll, 64'h101AE, 0, 0, 0, 0, 0);
      drv(64'h0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      expect_out("rst2_exit", MAll, 64'h101AE, 0, 0, 0, 0, 0);
      drv(64'h101AE, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("rst2_seq", MAll, 64'h101B2, 0, 0, 0, 0, 0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() > 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
